// File: rtl/aes128_dec_iter.sv
// Iterative AES-128 decryptor: one inverse round per clock, with round keys derived
// on the fly. The forward schedule runs up to round key 10, then the inverse
// schedule walks back to round key 0. An optional cache keeps the last round key 10
// so that a repeated cipher key skips forward expansion.
`timescale 1ns/1ps
module aes128_dec_iter #(
    parameter int unsigned KEY_CACHE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] data,
    input  logic [127:0] key,
    output logic         ready,
    output logic         done,
    output logic [127:0] de_data
);

    // Forward S-box. Byte i is stored at bits [8*(255-i) +: 8].
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Inverse S-box, same layout.
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    typedef enum logic [2:0] {StIdle, StKeyExp, StAddKey, StRound, StFinal} state_e;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // GF(2^8) multiply by a small constant (9, 11, 13 or 14 here).
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] m);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // SubWord(RotWord(w)) ^ {rc, 0, 0, 0}
    function automatic logic [31:0] sched_t(input logic [31:0] w, input logic [7:0] rc);
        return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])} ^ {rc, 24'h0};
    endfunction

    function automatic logic [127:0] key_fwd(input logic [127:0] rk, input logic [7:0] rc);
        logic [31:0] n0, n1, n2, n3;
        n0 = rk[127:96] ^ sched_t(rk[31:0], rc);
        n1 = rk[95:64] ^ n0;
        n2 = rk[63:32] ^ n1;
        n3 = rk[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // Recovers the previous round key from the current one (w4..w7 -> w0..w3).
    function automatic logic [127:0] key_inv(input logic [127:0] rk, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w3 = rk[31:0] ^ rk[63:32];
        w2 = rk[63:32] ^ rk[95:64];
        w1 = rk[95:64] ^ rk[127:96];
        w0 = rk[127:96] ^ sched_t(w3, rc);
        return {w0, w1, w2, w3};
    endfunction

    // Byte r+4c is row r, column c; row r rotates right by r columns.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gmul(a0, 4'd14) ^ gmul(a1, 4'd11) ^ gmul(a2, 4'd13) ^ gmul(a3, 4'd9);
            o[119-32*c -: 8] = gmul(a0, 4'd9) ^ gmul(a1, 4'd14) ^ gmul(a2, 4'd11) ^ gmul(a3, 4'd13);
            o[111-32*c -: 8] = gmul(a0, 4'd13) ^ gmul(a1, 4'd9) ^ gmul(a2, 4'd14) ^ gmul(a3, 4'd11);
            o[103-32*c -: 8] = gmul(a0, 4'd11) ^ gmul(a1, 4'd13) ^ gmul(a2, 4'd9) ^ gmul(a3, 4'd14);
        end
        return o;
    endfunction

    state_e       st_q;
    logic [3:0]   rnd_q;
    logic [127:0] data_q;
    logic [127:0] state_q;
    logic [127:0] rk_q;
    logic [127:0] cache_key_q;
    logic [127:0] cache_rk_q;
    logic         cache_vld_q;
    logic         ready_q;
    logic         done_q;
    logic [127:0] de_data_q;

    logic [127:0] rk_fwd;
    logic [127:0] rk_inv;
    logic [127:0] isr;
    logic         cache_hit;

    // Shared round datapath: next forward/inverse key and InvSubBytes(InvShiftRows(state)).
    always_comb begin
        rk_fwd    = key_fwd(rk_q, rcon(rnd_q));
        // rnd_q holds r, so stepping back from rk_(r+1) uses rcon_(r+1); rnd_q=0 in FINAL.
        rk_inv    = key_inv(rk_q, rcon(rnd_q + 4'd1));
        isr       = inv_sub_bytes(inv_shift_rows(state_q));
        cache_hit = (KEY_CACHE != 0) && cache_vld_q && (key == cache_key_q);
    end

    // Control FSM together with all state, key, cache and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q        <= StIdle;
            rnd_q       <= 4'd0;
            data_q      <= '0;
            state_q     <= '0;
            rk_q        <= '0;
            cache_key_q <= '0;
            cache_rk_q  <= '0;
            cache_vld_q <= 1'b0;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            de_data_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (st_q)
                StIdle: begin
                    if (start) begin
                        data_q  <= data;
                        ready_q <= 1'b0;
                        if (cache_hit) begin
                            rk_q <= cache_rk_q;
                            st_q <= StAddKey;
                        end else begin
                            rk_q        <= key;
                            rnd_q       <= 4'd1;
                            // Cache entry is rewritten by this expansion; invalid until E10.
                            cache_key_q <= key;
                            cache_vld_q <= 1'b0;
                            st_q        <= StKeyExp;
                        end
                    end
                end
                StKeyExp: begin
                    rk_q <= rk_fwd;
                    if (rnd_q == 4'd10) begin
                        cache_rk_q  <= rk_fwd;
                        cache_vld_q <= 1'b1;
                        state_q     <= data_q ^ rk_fwd;
                        rnd_q       <= 4'd9;
                        st_q        <= StRound;
                    end else begin
                        rnd_q <= rnd_q + 4'd1;
                    end
                end
                StAddKey: begin
                    state_q <= data_q ^ cache_rk_q;
                    rnd_q   <= 4'd9;
                    st_q    <= StRound;
                end
                StRound: begin
                    rk_q    <= rk_inv;
                    state_q <= inv_mix_columns(isr ^ rk_inv);
                    if (rnd_q == 4'd1) begin
                        rnd_q <= 4'd0;
                        st_q  <= StFinal;
                    end else begin
                        rnd_q <= rnd_q - 4'd1;
                    end
                end
                StFinal: begin
                    de_data_q <= isr ^ rk_inv;
                    done_q    <= 1'b1;
                    ready_q   <= 1'b1;
                    st_q      <= StIdle;
                end
                default: begin
                    ready_q <= 1'b1;
                    st_q    <= StIdle;
                end
            endcase
        end
    end

    assign ready   = ready_q;
    assign done    = done_q;
    assign de_data = de_data_q;

endmodule

// File: tb/tb_aes128_dec_iter.sv
// Scoreboard bench for aes128_dec_iter: known-answer vectors, loopback through a
// reference encryptor, busy-time input noise, back-to-back issue and resets.
`timescale 1ns/1ps
module tb_aes128_dec_iter;

    localparam logic [2047:0] TB_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [127:0] K0  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C0  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P0  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CZ  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [127:0] KB  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CB  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PB  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KL  = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] PL  = 128'h112233445566778899aabbccddeeff00;
    localparam logic [127:0] ONE = 128'hffffffffffffffffffffffffffffffff;

    typedef struct {
        logic [127:0] pt;
        int           lat;
        int           acc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start, nc_start;
    logic [127:0] data, key, nc_data, nc_key;
    logic         ready, done, nc_ready, nc_done;
    logic [127:0] de_data, nc_de_data;

    exp_t sb[$];
    exp_t sb_nc[$];
    exp_t mon_e, mon_nc_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic prev_done = 1'b0;
    logic prev_nc_done = 1'b0;

    aes128_dec_iter #(.KEY_CACHE(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .data(data), .key(key),
        .ready(ready), .done(done), .de_data(de_data)
    );

    aes128_dec_iter #(.KEY_CACHE(0)) u_dut_nc (
        .clk(clk), .rst_n(rst_n), .start(nc_start), .data(nc_data), .key(nc_key),
        .ready(nc_ready), .done(nc_done), .de_data(nc_de_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] tb_sb(input logic [7:0] b);
        return TB_SBOX[2047 - 8 * int'(b) -: 8];
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Reference forward AES-128 (stands in for the encryptor on the link).
    function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] k);
        logic [127:0] s, t, rk;
        logic [31:0]  w;
        logic [7:0]   rc, a0, a1, a2, a3;
        s  = pt ^ k;
        rk = k;
        rc = 8'h01;
        for (int r = 1; r <= 10; r++) begin
            w = rk[31:0];
            w = {tb_sb(w[23:16]), tb_sb(w[15:8]), tb_sb(w[7:0]), tb_sb(w[31:24])} ^ {rc, 24'h0};
            rk[127:96] = rk[127:96] ^ w;
            rk[95:64]  = rk[95:64] ^ rk[127:96];
            rk[63:32]  = rk[63:32] ^ rk[95:64];
            rk[31:0]   = rk[31:0] ^ rk[63:32];
            rc = xt(rc);
            for (int i = 0; i < 16; i++) t[127-8*i -: 8] = tb_sb(s[127-8*i -: 8]);
            for (int c = 0; c < 4; c++)
                for (int q = 0; q < 4; q++)
                    s[127-8*(q+4*c) -: 8] = t[127-8*(q+4*((c+q)%4)) -: 8];
            if (r != 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[127-32*c -: 8];
                    a1 = s[119-32*c -: 8];
                    a2 = s[111-32*c -: 8];
                    a3 = s[103-32*c -: 8];
                    s[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end
            s = s ^ rk;
        end
        return s;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Call at a negedge; waits for ready, presents one request and records its expectation.
    task automatic issue(input bit nc, input logic [127:0] d, input logic [127:0] k,
                         input logic [127:0] pt, input int lat);
        int   g;
        exp_t e;
        g = 0;
        while (!(nc ? nc_ready : ready) && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (g >= 100) begin
            checks++;
            errors++;
            $display("FAIL issue_wait: ready got 0, expected 1 within 100 cycles");
        end else begin
            e.pt  = pt;
            e.lat = lat;
            e.acc = cyc + 1;
            if (nc) begin
                nc_start = 1'b1; nc_data = d; nc_key = k;
                sb_nc.push_back(e);
            end else begin
                start = 1'b1; data = d; key = k;
                sb.push_back(e);
            end
            @(posedge clk);
            #1;
            if (nc) nc_start = 1'b0;
            else start = 1'b0;
        end
    endtask

    // Monitor for the cached instance.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) begin
                chk("done_single_cycle", {127'd0, prev_done}, 128'd0);
                chk("ready_with_done", {127'd0, ready}, 128'd1);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1, expected no pending request");
                end else begin
                    mon_e = sb.pop_front();
                    chk("plaintext", de_data, mon_e.pt);
                    chk("latency", 128'(cyc - mon_e.acc), 128'(mon_e.lat));
                end
            end else if (sb.size() > 0 && cyc - sb[0].acc > 40) begin
                checks++;
                errors++;
                $display("FAIL timeout: got no done, expected done within 40 cycles");
                void'(sb.pop_front());
            end
        end
        prev_done = done;
    end

    // Monitor for the uncached instance.
    always @(negedge clk) begin
        if (rst_n) begin
            if (nc_done) begin
                chk("nc_done_single_cycle", {127'd0, prev_nc_done}, 128'd0);
                if (sb_nc.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL nc_unexpected_done: got done=1, expected no pending request");
                end else begin
                    mon_nc_e = sb_nc.pop_front();
                    chk("nc_plaintext", nc_de_data, mon_nc_e.pt);
                    chk("nc_latency", 128'(cyc - mon_nc_e.acc), 128'(mon_nc_e.lat));
                end
            end else if (sb_nc.size() > 0 && cyc - sb_nc[0].acc > 40) begin
                checks++;
                errors++;
                $display("FAIL nc_timeout: got no done, expected done within 40 cycles");
                void'(sb_nc.pop_front());
            end
        end
        prev_nc_done = nc_done;
    end

    initial begin
        int g;
        start = 1'b0; data = '0; key = '0;
        nc_start = 1'b0; nc_data = '0; nc_key = '0;
        repeat (3) @(negedge clk);
        chk("reset_ready", {127'd0, ready}, 128'd1);
        chk("reset_done", {127'd0, done}, 128'd0);
        chk("reset_de_data", de_data, 128'd0);
        chk("model_fips", aes_enc(P0, K0), C0);
        rst_n = 1'b1;

        // Known answers: first miss, then a cache hit on the same key, then key=0.
        @(negedge clk); issue(0, C0, K0, P0, 20);
        @(negedge clk); issue(0, C0, K0, P0, 11);
        @(negedge clk); issue(0, CZ, '0, '0, 20);
        // Loopback through the reference encryptor; every key differs from the last.
        @(negedge clk); issue(0, aes_enc(PL, KL), KL, PL, 20);
        @(negedge clk); issue(0, aes_enc('0, '0), '0, '0, 20);
        @(negedge clk); issue(0, aes_enc(ONE, ONE), ONE, ONE, 20);

        // Noise on start/data/key while busy, then a new request in the done cycle.
        @(negedge clk); issue(0, CB, KB, PB, 20);
        g = 0;
        while (!done && g < 100) begin
            start = 1'($urandom_range(0, 1));
            data  = {$urandom, $urandom, $urandom, $urandom};
            key   = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            g++;
        end
        issue(0, CB, KB, PB, 11);

        // Reset after E7 of key expansion: outputs clear at once, in-flight result dropped.
        @(negedge clk); issue(0, C0, K0, P0, 20);
        repeat (7) @(posedge clk);
        #2 rst_n = 1'b0;
        sb.delete();
        #1;
        chk("midrst_ready", {127'd0, ready}, 128'd1);
        chk("midrst_done", {127'd0, done}, 128'd0);
        chk("midrst_de_data", de_data, 128'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); issue(0, C0, K0, P0, 20);
        @(negedge clk); issue(0, C0, K0, P0, 11);

        // Reset while idle must invalidate the cache as well.
        g = 0;
        while (sb.size() > 0 && g < 100) begin
            @(negedge clk);
            g++;
        end
        @(negedge clk); rst_n = 1'b0;
        #1 chk("idlerst_de_data", de_data, 128'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); issue(0, C0, K0, P0, 20);

        // Without the cache a repeated key still needs full expansion.
        @(negedge clk); issue(1, C0, K0, P0, 20);
        @(negedge clk); issue(1, C0, K0, P0, 20);

        g = 0;
        while ((sb.size() > 0 || sb_nc.size() > 0) && g < 200) begin
            @(negedge clk);
            g++;
        end
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
